regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-ported register file with a per-register busy scoreboard and a power-up clearing sweep.
// Latency: combinational reads (optional same-cycle write forwarding), writes and busy updates take effect at the clock edge.
// Backpressure: none; ready stays low during the clearing sweep and all writes and allocates are dropped until it rises.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic [ADDR_W-1:0]   ra_addr,
    input  logic [ADDR_W-1:0]   rb_addr,
    output logic [DATA_W-1:0]   ra_data,
    output logic [DATA_W-1:0]   rb_data,
    output logic                ra_busy,
    output logic                rb_busy,
    input  logic                w0_en,
    input  logic [ADDR_W-1:0]   w0_addr,
    input  logic [DATA_W-1:0]   w0_data,
    input  logic [DATA_W/8-1:0] w0_be,
    input  logic                w1_en,
    input  logic [ADDR_W-1:0]   w1_addr,
    input  logic [DATA_W-1:0]   w1_data,
    input  logic                alloc_en,
    input  logic [ADDR_W-1:0]   alloc_addr
);
    localparam int NREGS = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [NREGS-1:0]    busy;
    logic                w0_acc, w1_acc, alloc_acc;

    // Register 0 is hardwired to zero, so nothing addressed to it is ever accepted.
    assign w0_acc    = ready && w0_en    && (w0_addr    != '0);
    assign w1_acc    = ready && w1_en    && (w1_addr    != '0);
    assign alloc_acc = ready && alloc_en && (alloc_addr != '0);

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && cnt == ADDR_W'(NREGS - 1)) state_nxt = RUN;
    end

    always_comb begin
        ready = (state == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              cnt <= ADDR_W'(1);
        else if (state == INIT) cnt <= cnt + ADDR_W'(1);
    end

    // Storage has no reset; the sweep zeroes it. Port 1 is assigned last so it wins on a collision.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            regs[cnt] <= '0;
        end else begin
            if (w0_acc) regs[w0_addr] <= merge(regs[w0_addr], w0_data, w0_be);
            if (w1_acc) regs[w1_addr] <= w1_data;
        end
    end

    // Allocate is applied after the clears so a same-cycle allocate keeps the register busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (w0_acc)    busy[w0_addr]    <= 1'b0;
            if (w1_acc)    busy[w1_addr]    <= 1'b0;
            if (alloc_acc) busy[alloc_addr] <= 1'b1;
        end
    end

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = regs[a];
        if (BYPASS != 0) begin
            if (w0_acc && w0_addr == a) v = merge(v, w0_data, w0_be);
            if (w1_acc && w1_addr == a) v = w1_data;
        end
        if (!ready || a == '0) v = '0;
        return v;
    endfunction

    function automatic logic rd_busy(input logic [ADDR_W-1:0] a);
        logic b;
        b = ready && busy[a];
        if (BYPASS != 0 && ((w0_acc && w0_addr == a) || (w1_acc && w1_addr == a))) b = 1'b0;
        return b;
    endfunction

    assign ra_data = rd_val(ra_addr);
    assign rb_data = rd_val(rb_addr);
    assign ra_busy = rd_busy(ra_addr);
    assign rb_busy = rd_busy(rb_addr);

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: forwarding and non-forwarding instances share stimulus.
// Latency: outputs sampled at the falling edge, reference model advanced at each rising edge.
// Backpressure: none; every wait on ready is bounded by a cycle budget.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra_addr, rb_addr, w0_addr, w1_addr, alloc_addr;
    logic [31:0] w0_data, w1_data;
    logic [3:0]  w0_be;
    logic        w0_en, w1_en, alloc_en;

    logic        ready1, ra_busy1, rb_busy1, ready0, ra_busy0, rb_busy0;
    logic [31:0] ra_data1, rb_data1, ra_data0, rb_data0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem   [32];
    bit          mbusy [32];
    bit          mready;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .ready(ready1),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data1), .rb_data(rb_data1),
        .ra_busy(ra_busy1), .rb_busy(rb_busy1),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data), .w0_be(w0_be),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .ready(ready0),
        .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(ra_data0), .rb_data(rb_data0),
        .ra_busy(ra_busy0), .rb_busy(rb_busy0),
        .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data), .w0_be(w0_be),
        .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr)
    );

    typedef struct {
        logic        w0e; logic [4:0] w0a; logic [31:0] w0d; logic [3:0] w0b;
        logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
        logic        ae;  logic [4:0] aa;
        logic [4:0]  ra;  logic [4:0] rb;
        logic [31:0] e_ra; logic e_rab; logic [31:0] e_rb; logic e_rbb;
        logic [31:0] e_ra_nb;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        w0_en = 0; w0_addr = 0; w0_data = 0; w0_be = 0;
        w1_en = 0; w1_addr = 0; w1_data = 0;
        alloc_en = 0; alloc_addr = 0;
    endtask

    // Value register a will hold after the coming edge, from the write rules alone.
    function automatic logic [31:0] nxt_val(input int a);
        logic [31:0] v;
        v = mem[a];
        if (mready && a != 0 && w0_en && w0_addr == a)
            for (int i = 0; i < 4; i++) if (w0_be[i]) v[8*i +: 8] = w0_data[8*i +: 8];
        if (mready && a != 0 && w1_en && w1_addr == a) v = w1_data;
        return v;
    endfunction

    function automatic bit hit(input int a);
        return mready && a != 0 && ((w0_en && w0_addr == a) || (w1_en && w1_addr == a));
    endfunction

    function automatic logic [31:0] exp_data(input int a, input bit byp);
        if (!mready || a == 0) return 32'h0;
        return byp ? nxt_val(a) : mem[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        if (!mready || a == 0) return 1'b0;
        if (byp && hit(a)) return 1'b0;
        return mbusy[a];
    endfunction

    task automatic eval();
        @(negedge clk);
        chk("model ra_data byp", ra_data1, exp_data(ra_addr, 1));
        chk("model rb_data byp", rb_data1, exp_data(rb_addr, 1));
        chk("model ra_busy byp", {31'b0, ra_busy1}, {31'b0, exp_busy(ra_addr, 1)});
        chk("model rb_busy byp", {31'b0, rb_busy1}, {31'b0, exp_busy(rb_addr, 1)});
        chk("model ra_data nob", ra_data0, exp_data(ra_addr, 0));
        chk("model rb_data nob", rb_data0, exp_data(rb_addr, 0));
        chk("model ra_busy nob", {31'b0, ra_busy0}, {31'b0, exp_busy(ra_addr, 0)});
        chk("model rb_busy nob", {31'b0, rb_busy0}, {31'b0, exp_busy(rb_addr, 0)});
    endtask

    task automatic tick();
        logic [31:0] tmp [32];
        @(posedge clk);
        for (int a = 0; a < 32; a++) tmp[a] = nxt_val(a);
        for (int a = 1; a < 32; a++) begin
            if (hit(a)) mbusy[a] = 0;
            if (mready && alloc_en && alloc_addr == a) mbusy[a] = 1;
        end
        for (int a = 0; a < 32; a++) mem[a] = tmp[a];
        #1;
    endtask

    // Asserts reset just after an edge and checks the outputs drop with no clock.
    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        reset = 1;
        #2;
        chk({tag, " async ready byp"}, {31'b0, ready1}, 32'h0);
        chk({tag, " async ready nob"}, {31'b0, ready0}, 32'h0);
        chk({tag, " async rb_busy"}, {31'b0, rb_busy1}, 32'h0);
        @(negedge clk);
        reset = 0;
        mready = 0;
    endtask

    task automatic count_ready(input string tag);
        int n;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == 5) begin
                chk({tag, " init ra_data"}, ra_data1, 32'h0);
                chk({tag, " init ra_busy"}, {31'b0, ra_busy1}, 32'h0);
            end
            if (ready1) break;
        end
        idle();
        chk({tag, " edges to ready"}, n, 31);
        chk({tag, " ready nob"}, {31'b0, ready0}, 32'h1);
        for (int a = 0; a < 32; a++) begin mem[a] = 0; mbusy[a] = 0; end
        mready = 1;
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        tbl[0]  = '{1,5'd0,32'h0,4'h0, 1,5'd5,32'hAABBCCDD, 0,5'd0, 5'd5,5'd0, 32'hAABBCCDD,0,32'h0,0, 32'h0};
        tbl[1]  = '{1,5'd5,32'h11223344,4'h5, 0,5'd0,32'h0, 0,5'd0, 5'd5,5'd0, 32'hAA22CC44,0,32'h0,0, 32'hAABBCCDD};
        tbl[2]  = '{0,5'd0,32'h0,4'h0, 0,5'd0,32'h0, 0,5'd0, 5'd5,5'd0, 32'hAA22CC44,0,32'h0,0, 32'hAA22CC44};
        tbl[3]  = '{1,5'd5,32'h11223344,4'h5, 1,5'd5,32'hDEADBEEF, 0,5'd0, 5'd5,5'd0, 32'hDEADBEEF,0,32'h0,0, 32'hAA22CC44};
        tbl[4]  = '{0,5'd0,32'h0,4'h0, 0,5'd0,32'h0, 0,5'd0, 5'd5,5'd0, 32'hDEADBEEF,0,32'h0,0, 32'hDEADBEEF};
        tbl[5]  = '{0,5'd0,32'h0,4'h0, 1,5'd7,32'h1234, 0,5'd0, 5'd7,5'd0, 32'h1234,0,32'h0,0, 32'h0};
        tbl[6]  = '{0,5'd0,32'h0,4'h0, 0,5'd0,32'h0, 1,5'd9, 5'd7,5'd9, 32'h1234,0,32'h0,0, 32'h1234};
        tbl[7]  = '{0,5'd0,32'h0,4'h0, 0,5'd0,32'h0, 0,5'd0, 5'd7,5'd9, 32'h1234,0,32'h0,1, 32'h1234};
        tbl[8]  = '{0,5'd0,32'h0,4'h0, 1,5'd9,32'h99, 0,5'd0, 5'd7,5'd9, 32'h1234,0,32'h99,0, 32'h1234};
        tbl[9]  = '{0,5'd0,32'h0,4'h0, 0,5'd0,32'h0, 0,5'd0, 5'd7,5'd9, 32'h1234,0,32'h99,0, 32'h1234};
        tbl[10] = '{1,5'd9,32'h55,4'hF, 0,5'd0,32'h0, 1,5'd9, 5'd7,5'd9, 32'h1234,0,32'h55,0, 32'h1234};
        tbl[11] = '{0,5'd0,32'h0,4'h0, 0,5'd0,32'h0, 0,5'd0, 5'd7,5'd9, 32'h1234,0,32'h55,1, 32'h1234};
        tbl[12] = '{1,5'd0,32'hFFFF,4'hF, 1,5'd0,32'hFFFF, 1,5'd0, 5'd0,5'd0, 32'h0,0,32'h0,0, 32'h0};
        tbl[13] = '{0,5'd0,32'h0,4'h0, 0,5'd0,32'h0, 0,5'd0, 5'd0,5'd0, 32'h0,0,32'h0,0, 32'h0};
        tbl[14] = '{1,5'd9,32'hFFFFFFFF,4'h0, 0,5'd0,32'h0, 0,5'd0, 5'd5,5'd9, 32'hDEADBEEF,0,32'h55,0, 32'hDEADBEEF};
        tbl[15] = '{0,5'd0,32'h0,4'h0, 0,5'd0,32'h0, 0,5'd0, 5'd5,5'd9, 32'hDEADBEEF,0,32'h55,0, 32'hDEADBEEF};

        mready = 0;
        idle();
        ra_addr = 0; rb_addr = 0;
        reset = 1;
        #3;
        chk("por ready byp", {31'b0, ready1}, 32'h0);
        chk("por ready nob", {31'b0, ready0}, 32'h0);
        @(negedge clk);
        reset = 0;

        // Writes and allocates during the sweep must be dropped.
        w1_en = 1; w1_addr = 3; w1_data = 32'hFFFF; alloc_en = 1; alloc_addr = 3; ra_addr = 3;
        count_ready("sweep1");

        for (int a = 0; a < 32; a++) begin
            ra_addr = 5'(a); rb_addr = 5'(31 - a);
            #1;
            chk("post-sweep ra_data", ra_data1, 32'h0);
            chk("post-sweep rb_data nob", rb_data0, 32'h0);
        end
        ra_addr = 3; #1;
        chk("init alloc ignored", {31'b0, ra_busy1}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            w0_en = tbl[i].w0e; w0_addr = tbl[i].w0a; w0_data = tbl[i].w0d; w0_be = tbl[i].w0b;
            w1_en = tbl[i].w1e; w1_addr = tbl[i].w1a; w1_data = tbl[i].w1d;
            alloc_en = tbl[i].ae; alloc_addr = tbl[i].aa;
            ra_addr = tbl[i].ra; rb_addr = tbl[i].rb;
            eval();
            chk($sformatf("vec%0d ra_data", i), ra_data1, tbl[i].e_ra);
            chk($sformatf("vec%0d ra_busy", i), {31'b0, ra_busy1}, {31'b0, tbl[i].e_rab});
            chk($sformatf("vec%0d rb_data", i), rb_data1, tbl[i].e_rb);
            chk($sformatf("vec%0d rb_busy", i), {31'b0, rb_busy1}, {31'b0, tbl[i].e_rbb});
            chk($sformatf("vec%0d ra_data nob", i), ra_data0, tbl[i].e_ra_nb);
            tick();
        end

        for (int i = 0; i < 400; i++) begin
            w0_en = 1'($urandom_range(0, 1)); w0_addr = rnd_addr(); w0_data = $urandom; w0_be = 4'($urandom);
            w1_en = ($urandom_range(0, 3) == 0); w1_addr = rnd_addr(); w1_data = $urandom;
            alloc_en = ($urandom_range(0, 2) == 0); alloc_addr = rnd_addr();
            ra_addr = rnd_addr(); rb_addr = rnd_addr();
            eval();
            tick();
        end

        // Reset during RUN with a busy register outstanding.
        idle();
        alloc_en = 1; alloc_addr = 9; rb_addr = 9;
        eval(); tick();
        idle();
        eval();
        chk("busy before reset", {31'b0, rb_busy1}, 32'h1);
        do_reset("run");
        count_ready("sweep2");
        rb_addr = 9; #1;
        chk("busy cleared by reset", {31'b0, rb_busy1}, 32'h0);

        do_reset("mid");
        repeat (10) @(posedge clk);
        #1;
        chk("mid-sweep ready", {31'b0, ready1}, 32'h0);
        do_reset("mid2");
        count_ready("sweep3");
        ra_addr = 5; rb_addr = 7; #1;
        chk("swept r5", ra_data1, 32'h0);
        chk("swept r7", rb_data0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
